// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, legality check
// and the command FSM state encoding.
package alu_pkg;

  localparam logic [7:0] OP_ADD = 8'h00;
  localparam logic [7:0] OP_1   = 8'h01;
  localparam logic [7:0] OP_2   = 8'h02;
  localparam logic [7:0] OP_3   = 8'h03;
  localparam logic [7:0] OP_4   = 8'h04;
  localparam logic [7:0] OP_8   = 8'h08;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_A   = 3'd1,
    GET_B   = 3'd2,
    EXEC    = 3'd3,
    SEND_HI = 3'd4,
    SEND_LO = 3'd5
  } state_e;

  // Opcode bytes the ALU understands; anything else is dropped and counted.
  function automatic logic is_legal_op(input logic [7:0] op);
    logic legal;
    case (op)
      OP_ADD, OP_1, OP_2, OP_3, OP_4, OP_8: legal = 1'b1;
      default:                              legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Byte-stream interface of the sequencer: a command input stream and a
// result output stream, both valid/ready.
interface alu_cmd_sequencer_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  // Host / bridge side: produces commands, consumes results.
  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready
  );

  // Sequencer side: consumes commands, produces results.
  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready
  );

endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command front end for the combinational ALU. Parses opcode/A/B bytes from
// the input stream, drives the registered ALU inputs, waits ALU_LAT cycles,
// then returns the 16-bit result as two bytes, high byte first.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int OP_W    = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_cmd_sequencer_if.slave   bus,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  output logic [OP_W-1:0]      alu_op,
  input  logic [15:0]          alu_result,
  output logic                 busy,
  output logic [7:0]           err_cnt
);

  localparam logic [3:0] LAT = 4'(ALU_LAT);

  state_e            state_q, state_d;
  logic [7:0]        alu_a_q, alu_a_d;
  logic [7:0]        alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [7:0]        res_lo_q, res_lo_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic [3:0]        lat_cnt_q, lat_cnt_d;

  logic              in_ready;
  logic              in_accept;
  logic              out_xfer;

  // Only the three parsing states take bytes; everything else backpressures.
  always_comb begin
    in_ready  = (state_q == IDLE) || (state_q == GET_A) || (state_q == GET_B);
    in_accept = in_ready && bus.in_valid;
    out_xfer  = out_valid_q && bus.out_ready;
  end

  // Next-state and datapath updates for the command FSM.
  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    res_lo_d    = res_lo_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_cnt_d   = err_cnt_q;
    lat_cnt_d   = lat_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (in_accept) begin
          if (is_legal_op(bus.in_data)) begin
            alu_op_d = bus.in_data[OP_W-1:0];
            state_d  = GET_A;
          end else if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      end
      GET_A: begin
        if (in_accept) begin
          alu_a_d = bus.in_data;
          state_d = GET_B;
        end
      end
      GET_B: begin
        if (in_accept) begin
          alu_b_d   = bus.in_data;
          lat_cnt_d = LAT;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        if (lat_cnt_q == 4'd0) begin
          res_lo_d    = alu_result[7:0];
          out_data_d  = alu_result[15:8];
          out_valid_d = 1'b1;
          state_d     = SEND_HI;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      SEND_HI: begin
        if (out_xfer) begin
          out_data_d = res_lo_q;
          state_d    = SEND_LO;
        end
      end
      SEND_LO: begin
        if (out_xfer) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      res_lo_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_cnt_q   <= '0;
      lat_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      res_lo_q    <= res_lo_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_cnt_q   <= err_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_op        = alu_op_q;
  assign busy          = (state_q != IDLE);
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed testbench for alu_cmd_sequencer with a behavioural ALU stand-in.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [5:0]  alu_op;
  logic [15:0] alu_result;
  logic        busy;
  logic [7:0]  err_cnt;

  int vectors     = 0;
  int miscompares = 0;

  alu_cmd_sequencer_if sif ();

  alu_cmd_sequencer #(.ALU_LAT(1), .OP_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (sif.slave),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .busy       (busy),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: add, sub, mul, and, or, xor.
  always_comb begin
    case (alu_op)
      6'h00:   alu_result = {8'h00, alu_a} + {8'h00, alu_b};
      6'h01:   alu_result = {8'h00, alu_a} - {8'h00, alu_b};
      6'h02:   alu_result = {8'h00, alu_a} * {8'h00, alu_b};
      6'h03:   alu_result = {8'h00, alu_a & alu_b};
      6'h04:   alu_result = {8'h00, alu_a | alu_b};
      6'h08:   alu_result = {8'h00, alu_a ^ alu_b};
      default: alu_result = 16'h0000;
    endcase
  end

  // Global watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Offer one byte and hold it until accepted (bounded wait).
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    sif.in_data  = b;
    sif.in_valid = 1'b1;
    while (!sif.in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!sif.in_ready) begin
      vectors++; miscompares++;
      $display("[TB] FAIL send_timeout: in_ready=0 required 1 (byte %h)", b);
    end
    @(posedge clk); #1;
    sif.in_valid = 1'b0;
  endtask

  // Wait for an output byte (bounded) and take it.
  task automatic recv_byte(output logic [7:0] d);
    int n = 0;
    sif.out_ready = 1'b1;
    while (!sif.out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!sif.out_valid) begin
      vectors++; miscompares++;
      $display("[TB] FAIL recv_timeout: out_valid=0 required 1");
      d = 8'hxx;
    end else begin
      d = sif.out_data;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    vectors++; if (sif.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_out_valid: got %b expected 0", sif.out_valid); end
    vectors++; if (sif.out_data !== 8'h00) begin miscompares++; $display("[TB] FAIL rst_out_data: got %h expected 00", sif.out_data); end
    vectors++; if ({alu_a, alu_b, alu_op} !== 22'h0) begin miscompares++; $display("[TB] FAIL rst_alu_inputs: got %h expected 0", {alu_a, alu_b, alu_op}); end
    vectors++; if (err_cnt !== 8'h00) begin miscompares++; $display("[TB] FAIL rst_err_cnt: got %h expected 00", err_cnt); end
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++; if (sif.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_in_ready: got %b expected 1", sif.in_ready); end
  endtask

  task automatic test_add();
    logic [7:0] d;
    send_byte(8'h00); send_byte(8'h05); send_byte(8'h03);
    vectors++; if (sif.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL add_lat0: out_valid got %b expected 0", sif.out_valid); end
    @(posedge clk); #1;
    vectors++; if (sif.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL add_lat1: out_valid got %b expected 0", sif.out_valid); end
    @(posedge clk); #1;
    vectors++; if (sif.out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL add_lat2: out_valid got %b expected 1", sif.out_valid); end
    vectors++; if ({alu_op, alu_a, alu_b} !== {6'h00, 8'h05, 8'h03}) begin miscompares++; $display("[TB] FAIL add_operands: got %h/%h/%h expected 00/05/03", alu_op, alu_a, alu_b); end
    recv_byte(d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("[TB] FAIL add_hi: got %h expected 00", d); end
    recv_byte(d);
    vectors++; if (d !== 8'h08) begin miscompares++; $display("[TB] FAIL add_lo: got %h expected 08", d); end
    vectors++; if (busy !== 1'b0 || sif.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL add_done: busy=%b out_valid=%b expected 0/0", busy, sif.out_valid); end
  endtask

  task automatic test_wide();
    logic [7:0] d;
    send_byte(8'h02); send_byte(8'hFF); send_byte(8'hFF);
    recv_byte(d);
    vectors++; if (d !== 8'hFE) begin miscompares++; $display("[TB] FAIL wide_hi: got %h expected FE", d); end
    recv_byte(d);
    vectors++; if (d !== 8'h01) begin miscompares++; $display("[TB] FAIL wide_lo: got %h expected 01", d); end
  endtask

  task automatic test_illegal();
    logic [7:0] d;
    send_byte(8'h07);
    vectors++; if (err_cnt !== 8'h01) begin miscompares++; $display("[TB] FAIL illegal_err_cnt: got %h expected 01", err_cnt); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL illegal_stay_idle: busy got %b expected 0", busy); end
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h02);
    recv_byte(d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("[TB] FAIL illegal_hi: got %h expected 00", d); end
    recv_byte(d);
    vectors++; if (d !== 8'h03) begin miscompares++; $display("[TB] FAIL illegal_lo: got %h expected 03", d); end
  endtask

  task automatic test_backpressure();
    logic [7:0] d;
    int n = 0;
    sif.out_ready = 1'b0;
    send_byte(8'h00); send_byte(8'h05); send_byte(8'h03);
    while (!sif.out_valid && n < 50) begin @(posedge clk); #1; n++; end
    // Next command's opcode waits upstream while the sequencer is busy.
    sif.in_data  = 8'h00;
    sif.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (sif.out_valid !== 1'b1 || sif.out_data !== 8'h00 || sif.in_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL bp_hold[%0d]: out_valid=%b out_data=%h in_ready=%b expected 1/00/0", i, sif.out_valid, sif.out_data, sif.in_ready);
      end
      @(posedge clk); #1;
    end
    recv_byte(d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("[TB] FAIL bp_hi: got %h expected 00", d); end
    recv_byte(d);
    vectors++; if (d !== 8'h08) begin miscompares++; $display("[TB] FAIL bp_lo: got %h expected 08", d); end
    vectors++; if (sif.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_in_ready: got %b expected 1", sif.in_ready); end
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h01);
    recv_byte(d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("[TB] FAIL bp_next_hi: got %h expected 00", d); end
    recv_byte(d);
    vectors++; if (d !== 8'h02) begin miscompares++; $display("[TB] FAIL bp_next_lo: got %h expected 02", d); end
  endtask

  task automatic test_gaps();
    logic [7:0] d;
    logic [5:0] pattern;
    logic [7:0] bytes [3];
    int         k = 0;
    pattern  = 6'b101001;
    bytes[0] = 8'h00; bytes[1] = 8'h05; bytes[2] = 8'h03;
    for (int i = 0; i < 6; i++) begin
      sif.in_valid = pattern[i];
      sif.in_data  = pattern[i] ? bytes[k] : 8'hAA;
      if (pattern[i]) k++;
      @(posedge clk); #1;
      sif.in_valid = 1'b0;
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL gap_busy[%0d]: got %b expected 1", i, busy); end
    end
    vectors++; if ({alu_a, alu_b} !== {8'h05, 8'h03}) begin miscompares++; $display("[TB] FAIL gap_operands: got %h/%h expected 05/03", alu_a, alu_b); end
    recv_byte(d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("[TB] FAIL gap_hi: got %h expected 00", d); end
    recv_byte(d);
    vectors++; if (d !== 8'h08) begin miscompares++; $display("[TB] FAIL gap_lo: got %h expected 08", d); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    send_byte(8'h01); send_byte(8'h09);
    rst = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0 || sif.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_state: busy=%b in_ready=%b expected 0/1", busy, sif.in_ready); end
    vectors++; if ({alu_a, alu_b, alu_op} !== 22'h0) begin miscompares++; $display("[TB] FAIL rmid_alu_inputs: got %h expected 0", {alu_a, alu_b, alu_op}); end
    vectors++; if (err_cnt !== 8'h00) begin miscompares++; $display("[TB] FAIL rmid_err_cnt: got %h expected 00", err_cnt); end
    vectors++; if (sif.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_out_valid: got %b expected 0", sif.out_valid); end
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h02);
    recv_byte(d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("[TB] FAIL rmid_hi: got %h expected 00", d); end
    recv_byte(d);
    vectors++; if (d !== 8'h04) begin miscompares++; $display("[TB] FAIL rmid_lo: got %h expected 04", d); end
  endtask

  initial begin
    sif.in_data   = 8'h00;
    sif.in_valid  = 1'b0;
    sif.out_ready = 1'b1;
    test_reset();
    test_add();
    test_wide();
    test_illegal();
    test_backpressure();
    test_gaps();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Hardware front end for the combinational ALU. It consumes a byte stream of commands (opcode byte, operand A byte, operand B byte) over a valid/ready interface, drives the ALU inputs, and captures the 16-bit ALU result. It returns the result as two bytes on an output valid/ready stream, high byte first. It takes the place of file-driven stimulus, so a host or UART bridge can exercise the ALU in-system.

Parameters:
ALU_LAT, 1, cycles between ALU inputs becoming stable and result capture (1..15).
OP_W, 6, ALU op field width.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_data  in  8  command stream byte.
in_valid  in  1  in_data valid.
in_ready  out  1  sequencer accepts in_data this cycle.
out_data  out  8  result stream byte.
out_valid  out  1  out_data valid.
out_ready  in  1  downstream accepts out_data.
alu_a  out  8  ALU operand A (registered).
alu_b  out  8  ALU operand B (registered).
alu_op  out  OP_W  ALU opcode (registered).
alu_result  in  16  ALU result (combinational from alu_a/alu_b/alu_op).
busy  out  1  high whenever state != IDLE.
err_cnt  out  8  count of rejected opcode bytes, saturating at 0xFF.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (async assert, sync release):
  - state=IDLE; alu_a, alu_b, alu_op = 0; out_data=0; out_valid=0; err_cnt=0.
  - in_ready=1 after reset release.
- Handshake:
  - Input byte transfers when in_valid && in_ready at the rising edge.
  - Output byte transfers when out_valid && out_ready.
  - out_data and out_valid stay stable until the transfer; out_valid is never withdrawn without a transfer.
- Legal opcodes: 0x00 (add), 0x01, 0x02, 0x03, 0x04, 0x08. alu_op = opcode[OP_W-1:0].
- FSM states: IDLE, GET_A, GET_B, EXEC, SEND_HI, SEND_LO. in_ready=1 only in IDLE, GET_A, GET_B.
  - IDLE, byte accepted:
    - Legal opcode: latch into alu_op, go to GET_A.
    - Illegal opcode: drop the byte, err_cnt++ (saturating), stay in IDLE. No operand bytes are consumed.
  - GET_A, byte accepted: alu_a <= byte, go to GET_B.
  - GET_B, byte accepted: alu_b <= byte, go to EXEC, load latency counter with ALU_LAT.
  - EXEC: decrement counter each cycle. When it reaches 0, capture alu_result into a 16-bit holding register, set out_data=result[15:8], out_valid=1, go to SEND_HI.
  - SEND_HI, transfer: out_data=result[7:0], go to SEND_LO (out_valid stays 1).
  - SEND_LO, transfer: out_valid=0, go to IDLE.
- Latency: from acceptance of byte B, out_valid rises ALU_LAT+1 cycles later.
- No pipelining: one command in flight at a time. alu_a, alu_b and alu_op hold their values until the next command overwrites them.
- Backpressure: in_valid is ignored outside the accepting states. An upstream byte stays pending and is not lost.
- Stalls: in_valid low mid-command means wait indefinitely in GET_A or GET_B; there is no timeout.
- Reset mid-command: abort immediately. Partial operands are discarded, any pending output is dropped, err_cnt is cleared.

Decomposition:
- Shared package alu_pkg: opcode localparams (OP_ADD=0x00, OP_1=0x01, OP_2=0x02, OP_3=0x03, OP_4=0x04, OP_8=0x08), the opcode-legality function, and the FSM state enum.
- Sub-module: alu_cmd_sequencer instantiates nothing. The top-level pairs it with the existing alu. Any natural split (e.g. a byte serializer) stays inline; none is required.

Test Plan:
- Add: stream 0x00,0x05,0x03 with out_ready=1 and a bench ALU model -> alu_op=0, alu_a=0x05, alu_b=0x03; output bytes 0x00 then 0x08; out_valid rises 2 cycles after byte B (ALU_LAT=1).
- Wide result: op 0x02 with a=0xFF, b=0xFF and model result 0xFE01 -> output 0xFE then 0x01, high byte first.
- Illegal opcode: stream 0x07,0x00,0x01,0x02 -> err_cnt=1; 0x07 is dropped; 0x00 is parsed as an add of 0x01+0x02 -> output 0x00, 0x03.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_data holds 0x00 and in_ready stays 0; release -> both bytes delivered, then in_ready=1.
- Input gaps: in_valid toggled 1-0-0-1-0-1 across the three bytes -> same result as the gapless case; busy=1 throughout.
- Reset mid-command: assert rst after operand A -> all outputs return to reset values immediately; a following clean command 0x00,0x02,0x02 -> output 0x00, 0x04.
